// File: rtl/trap_sequencer.sv
// trap_sequencer: turns trap/MRET/CSR requests and boundary interrupts into CSR bus ops (csr_*) and one rsp_* response each; req_* in, irq/bnd mirrors in, irq_taken pulse out
module trap_sequencer #(
  parameter logic [3:0] CAUSE_ILLEGAL = 4'd2,
  parameter logic [3:0] CAUSE_SW_IRQ = 4'd3,
  parameter logic [3:0] CAUSE_EXT_IRQ = 4'd11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [3:0]  req_cause,
  input  logic [2:0]  req_csr_op,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_msie,
  input  logic        bnd_valid,
  input  logic [31:0] bnd_pc,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_fault,
  output logic        rsp_valid,
  output logic        rsp_redirect,
  output logic [31:0] rsp_pc,
  output logic [31:0] rsp_rdata,
  output logic        irq_taken
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, TRAP_ISSUE, TRAP_WAIT, RESP} state_t;
  state_t state;
  logic mret;
  logic [31:0] pc;
  logic ext_ok;
  logic [3:0] exc_cause;
  assign ext_ok = irq_ext & mie_meie;
  assign irq_taken = (state == IDLE) & ~reset & bnd_valid & mstatus_mie & (ext_ok | (irq_sw & mie_msie));
  assign req_ready = (state == IDLE) & ~reset & ~irq_taken;
  assign exc_cause = req_kind == 2'b11 ? CAUSE_ILLEGAL : req_cause;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      mret <= 1'b0;
      pc <= '0;
      csr_op <= 3'b100;
      csr_addr <= '0;
      csr_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_redirect <= 1'b0;
      rsp_pc <= '0;
      rsp_rdata <= '0;
    end else begin
      csr_op <= 3'b100;
      csr_addr <= '0;
      csr_wdata <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE:
          if (irq_taken) begin
            state <= TRAP_ISSUE;
            csr_op <= 3'b000;
            csr_addr <= {7'b0, 1'b1, (ext_ok ? CAUSE_EXT_IRQ : CAUSE_SW_IRQ)};
            csr_wdata <= bnd_pc;
          end else if (req_valid) begin
            mret <= req_kind == 2'b01;
            pc <= req_pc;
            if (req_kind[1] ^ req_kind[0]) begin
              state <= ISSUE;
              csr_op <= req_kind[0] ? 3'b001 : req_csr_op;
              csr_addr <= req_kind[0] ? '0 : req_csr_addr;
              csr_wdata <= req_kind[0] ? '0 : req_wdata;
            end else begin
              state <= TRAP_ISSUE;
              csr_op <= 3'b000;
              csr_addr <= {8'b0, exc_cause};
              csr_wdata <= req_pc;
            end
          end
        ISSUE: state <= WAIT;
        WAIT:
          if (~mret & csr_fault) begin
            state <= TRAP_ISSUE;
            csr_op <= 3'b000;
            csr_addr <= {8'b0, CAUSE_ILLEGAL};
            csr_wdata <= pc;
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_redirect <= mret;
            rsp_pc <= mret ? csr_rdata : rsp_pc;
            rsp_rdata <= mret ? rsp_rdata : csr_rdata;
          end
        TRAP_ISSUE: state <= TRAP_WAIT;
        TRAP_WAIT: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_redirect <= 1'b1;
          rsp_pc <= csr_rdata;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed bench for trap_sequencer with a small CSR unit, a transaction-level model checked every cycle, and literal checks
module tb_trap_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_kind = '0;
  logic [3:0] req_cause = '0;
  logic [2:0] req_csr_op = '0;
  logic [11:0] req_csr_addr = '0;
  logic [31:0] req_wdata = '0, req_pc = '0;
  logic irq_ext = 1'b0, irq_sw = 1'b0, mstatus_mie = 1'b0, mie_meie = 1'b0, mie_msie = 1'b0, bnd_valid = 1'b0;
  logic [31:0] bnd_pc = '0;
  logic [2:0] csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic csr_fault;
  logic rsp_valid, rsp_redirect, irq_taken;
  logic [31:0] rsp_pc, rsp_rdata;
  trap_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_cause(req_cause), .req_csr_op(req_csr_op), .req_csr_addr(req_csr_addr), .req_wdata(req_wdata),
    .req_pc(req_pc), .irq_ext(irq_ext), .irq_sw(irq_sw), .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .mie_msie(mie_msie), .bnd_valid(bnd_valid), .bnd_pc(bnd_pc), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_fault(csr_fault), .rsp_valid(rsp_valid),
    .rsp_redirect(rsp_redirect), .rsp_pc(rsp_pc), .rsp_rdata(rsp_rdata), .irq_taken(irq_taken)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  logic [31:0] env_r [int];
  logic [31:0] mdl_r [int];
  always @(posedge clk) begin
    int k;
    logic [31:0] old;
    csr_fault <= 1'b0;
    csr_rdata <= $urandom;
    if (csr_op == 3'b000) begin
      csr_rdata <= env_r[12'h305];
      env_r[12'h341] = csr_wdata;
      env_r[12'h342] = {20'b0, csr_addr};
    end else if (csr_op == 3'b001) begin
      csr_rdata <= env_r[12'h341];
      csr_fault <= 1'b1;
    end else if (csr_op[2] && csr_op[1:0] != 2'b00) begin
      k = int'(csr_addr);
      if (env_r.exists(k)) begin
        old = env_r[k];
        csr_rdata <= old;
        env_r[k] = csr_op == 3'b101 ? csr_wdata : csr_op == 3'b110 ? (old | csr_wdata) : (old & ~csr_wdata);
      end else csr_fault <= 1'b1;
    end
  end
  typedef struct packed {int c; logic [2:0] op; logic [11:0] a; logic [31:0] w;} bus_t;
  typedef struct packed {int c; logic red; logic [31:0] pc; logic [31:0] rd;} rsp_t;
  bus_t bq[$];
  rsp_t rq[$];
  int free_at = 0;
  logic [31:0] m_rd = '0;
  task automatic push_bus(input int c, input logic [2:0] op, input logic [11:0] a, input logic [31:0] w);
    bus_t b;
    b.c = c; b.op = op; b.a = a; b.w = w;
    bq.push_back(b);
  endtask
  task automatic push_rsp(input int c, input logic red, input logic [31:0] p, input logic [31:0] rd);
    rsp_t r;
    r.c = c; r.red = red; r.pc = p; r.rd = rd;
    rq.push_back(r);
  endtask
  task automatic push_trap(input int c, input logic irq, input logic [3:0] cause, input logic [31:0] epc);
    push_bus(c, 3'b000, {7'b0, irq, cause}, epc);
    push_rsp(c + 2, 1'b1, mdl_r[12'h305], m_rd);
    mdl_r[12'h341] = epc;
    mdl_r[12'h342] = {20'b0, 7'b0, irq, cause};
  endtask
  always @(negedge clk) begin
    logic idle_m, ext_m, irq_m;
    int k;
    logic [31:0] old;
    bus_t b;
    rsp_t r;
    if (reset) begin
      bq.delete();
      rq.delete();
      free_at = cyc + 1;
      m_rd = '0;
      chk("reset_req_ready", {31'b0, req_ready}, 0);
      chk("reset_irq_taken", {31'b0, irq_taken}, 0);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("reset_csr_op", {29'b0, csr_op}, 32'h4);
    end else begin
      idle_m = cyc >= free_at;
      ext_m = irq_ext & mie_meie;
      irq_m = idle_m & bnd_valid & mstatus_mie & (ext_m | (irq_sw & mie_msie));
      chk("req_ready", {31'b0, req_ready}, {31'b0, idle_m & ~irq_m});
      chk("irq_taken", {31'b0, irq_taken}, {31'b0, irq_m});
      if (irq_m) begin
        push_trap(cyc + 1, 1'b1, ext_m ? 4'd11 : 4'd3, bnd_pc);
        free_at = cyc + 4;
      end else if (idle_m && req_valid) begin
        free_at = cyc + 4;
        if (req_kind == 2'b00) push_trap(cyc + 1, 1'b0, req_cause, req_pc);
        else if (req_kind == 2'b11) push_trap(cyc + 1, 1'b0, 4'd2, req_pc);
        else if (req_kind == 2'b01) begin
          push_bus(cyc + 1, 3'b001, '0, '0);
          push_rsp(cyc + 3, 1'b1, mdl_r[12'h341], m_rd);
        end else begin
          push_bus(cyc + 1, req_csr_op, req_csr_addr, req_wdata);
          k = int'(req_csr_addr);
          if (mdl_r.exists(k)) begin
            old = mdl_r[k];
            mdl_r[k] = req_csr_op == 3'b101 ? req_wdata : req_csr_op == 3'b110 ? (old | req_wdata) : (old & ~req_wdata);
            m_rd = old;
            push_rsp(cyc + 3, 1'b0, '0, old);
          end else begin
            push_trap(cyc + 3, 1'b0, 4'd2, req_pc);
            free_at = cyc + 6;
          end
        end
      end
      if (bq.size() > 0 && bq[0].c == cyc) begin
        b = bq.pop_front();
        chk("bus_op", {29'b0, csr_op}, {29'b0, b.op});
        if (b.op != 3'b001) begin
          chk("bus_addr", {20'b0, csr_addr}, {20'b0, b.a});
          chk("bus_wdata", csr_wdata, b.w);
        end
      end else chk("bus_idle_op", {29'b0, csr_op}, 32'h4);
      if (rq.size() > 0 && rq[0].c == cyc) begin
        r = rq.pop_front();
        chk("rsp_valid", {31'b0, rsp_valid}, 1);
        chk("rsp_redirect", {31'b0, rsp_redirect}, {31'b0, r.red});
        if (r.red) chk("rsp_pc", rsp_pc, r.pc);
        chk("rsp_rdata", rsp_rdata, r.rd);
      end else chk("rsp_valid_idle", {31'b0, rsp_valid}, 0);
    end
  end
  logic [11:0] tr_addr = '0;
  logic [31:0] tr_wd = '0;
  int tr_cyc = 0;
  always @(negedge clk)
    if (csr_op == 3'b000) begin
      tr_addr = csr_addr;
      tr_wd = csr_wdata;
      tr_cyc = cyc;
    end
  int acc, lat, a1, a2;
  logic r_red;
  logic [31:0] r_pc, r_rd;
  task automatic drive(input logic [1:0] k, input logic [3:0] c, input logic [2:0] op, input logic [11:0] a, input logic [31:0] w, input logic [31:0] p);
    @(posedge clk);
    #2;
    req_valid = 1'b1; req_kind = k; req_cause = c; req_csr_op = op; req_csr_addr = a; req_wdata = w; req_pc = p;
  endtask
  task automatic accept();
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    req_kind = 2'($urandom); req_cause = 4'($urandom); req_csr_op = 3'($urandom);
    req_csr_addr = 12'($urandom); req_wdata = $urandom; req_pc = $urandom;
  endtask
  task automatic wait_rsp(input int from);
    lat = -1;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - from; r_red = rsp_redirect; r_pc = rsp_pc; r_rd = rsp_rdata;
      end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
  endtask
  task automatic req(input logic [1:0] k, input logic [3:0] c, input logic [2:0] op, input logic [11:0] a, input logic [31:0] w, input logic [31:0] p);
    drive(k, c, op, a, w, p);
    accept();
    wait_rsp(acc);
  endtask
  initial begin
    env_r[12'h305] = '0; env_r[12'h340] = '0; env_r[12'h341] = '0; env_r[12'h342] = '0;
    mdl_r[12'h305] = '0; mdl_r[12'h340] = '0; mdl_r[12'h341] = '0; mdl_r[12'h342] = '0;
    repeat (3) @(negedge clk);
    chk("rst_csr_addr", {20'b0, csr_addr}, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_rsp_pc", rsp_pc, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_redirect", {31'b0, rsp_redirect}, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    req(2'b10, 4'd0, 3'b101, 12'h305, 32'h100, 32'h10);
    chk("rw_lat", lat, 3); chk("rw_red", {31'b0, r_red}, 0); chk("rw_rdata", r_rd, 32'h0);
    req(2'b10, 4'd0, 3'b110, 12'h305, 32'h3, 32'h14);
    chk("rs_lat", lat, 3); chk("rs_rdata", r_rd, 32'h100);
    req(2'b10, 4'd0, 3'b111, 12'h305, 32'h3, 32'h18);
    chk("rc_rdata", r_rd, 32'h103);
    req(2'b00, 4'd8, 3'b000, 12'h0, 32'h0, 32'h40);
    chk("exc_lat", lat, 3); chk("exc_red", {31'b0, r_red}, 1); chk("exc_pc", r_pc, 32'h100);
    chk("exc_rdata_hold", r_rd, 32'h103); chk("exc_addr", {20'b0, tr_addr}, 32'h008);
    chk("exc_epc", tr_wd, 32'h40); chk("exc_issue_cyc", tr_cyc - acc, 1);
    req(2'b01, 4'd0, 3'b000, 12'h0, 32'h0, 32'h44);
    chk("mret_lat", lat, 3); chk("mret_red", {31'b0, r_red}, 1); chk("mret_pc", r_pc, 32'h40);
    req(2'b10, 4'd0, 3'b101, 12'h7FF, 32'h55, 32'h80);
    chk("fault_lat", lat, 5); chk("fault_pc", r_pc, 32'h100); chk("fault_addr", {20'b0, tr_addr}, 32'h002);
    chk("fault_epc", tr_wd, 32'h80); chk("fault_issue_cyc", tr_cyc - acc, 3); chk("fault_rdata_hold", r_rd, 32'h103);
    req(2'b11, 4'd9, 3'b000, 12'h0, 32'h0, 32'h90);
    chk("rsvd_lat", lat, 3); chk("rsvd_addr", {20'b0, tr_addr}, 32'h002); chk("rsvd_epc", tr_wd, 32'h90);
    @(posedge clk);
    #2;
    irq_ext = 1'b1; mie_meie = 1'b1; mstatus_mie = 1'b1; bnd_valid = 1'b1; bnd_pc = 32'h200;
    req_valid = 1'b1; req_kind = 2'b10; req_csr_op = 3'b110; req_csr_addr = 12'h340; req_wdata = '0; req_pc = 32'h1FC;
    @(negedge clk);
    chk("ext_irq_taken", {31'b0, irq_taken}, 1); chk("ext_irq_ready", {31'b0, req_ready}, 0);
    acc = cyc;
    @(posedge clk);
    #2;
    irq_ext = 1'b0; bnd_valid = 1'b0; req_valid = 1'b0;
    wait_rsp(acc);
    chk("ext_lat", lat, 3); chk("ext_addr", {20'b0, tr_addr}, 32'h01B); chk("ext_epc", tr_wd, 32'h200);
    chk("ext_pc", r_pc, 32'h100);
    @(posedge clk);
    #2;
    irq_ext = 1'b1; mie_meie = 1'b0; irq_sw = 1'b1; mie_msie = 1'b1; bnd_valid = 1'b1; bnd_pc = 32'h300;
    @(negedge clk);
    chk("sw_irq_taken", {31'b0, irq_taken}, 1);
    acc = cyc;
    @(posedge clk);
    #2;
    irq_ext = 1'b0; irq_sw = 1'b0; mie_msie = 1'b0; bnd_valid = 1'b0;
    wait_rsp(acc);
    chk("sw_lat", lat, 3); chk("sw_addr", {20'b0, tr_addr}, 32'h013); chk("sw_epc", tr_wd, 32'h300);
    mstatus_mie = 1'b0; irq_ext = 1'b1; mie_meie = 1'b1; bnd_valid = 1'b1;
    req(2'b10, 4'd0, 3'b101, 12'h340, 32'hABCD, 32'h304);
    chk("masked_lat", lat, 3); chk("masked_rdata", r_rd, 32'h0);
    irq_ext = 1'b0; mie_meie = 1'b0; bnd_valid = 1'b0;
    @(posedge clk);
    #2;
    req_valid = 1'b1; req_kind = 2'b10; req_csr_op = 3'b110; req_csr_addr = 12'h340; req_wdata = '0;
    a1 = -1;
    for (int i = 0; i < 20 && a1 < 0; i++) begin
      @(negedge clk);
      if (req_ready) a1 = cyc;
    end
    @(posedge clk);
    #2;
    req_csr_op = 3'b101; req_wdata = 32'h77;
    a2 = -1;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge clk);
      if (req_ready) a2 = cyc;
    end
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    chk("b2b_gap", a2 - a1, 4);
    wait_rsp(a2);
    chk("b2b_lat", lat, 3); chk("b2b_rdata", r_rd, 32'hABCD);
    drive(2'b10, 4'd0, 3'b110, 12'h340, 32'h0, 32'h400);
    accept();
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 1); chk("post_rst_op", {29'b0, csr_op}, 32'h4);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0); chk("post_rst_rdata", rsp_rdata, 0);
    a1 = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) a1++;
    end
    chk("post_rst_no_rsp", a1, 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
